// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared types and helpers for the RAM port arbiter
// Purpose: arbiter state and read-owner encodings, requester indices and a
// one-hot helper shared by ram_port_arbiter and rr_arbiter2.
// Ports: none (package).
package k_and_s_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_DBG  = 2'd2,
    ARB_LOCK = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } arb_owner_t;

  // Requester positions inside the two-bit request/grant vectors.
  localparam logic IDX_CORE = 1'b0;
  localparam logic IDX_DBG  = 1'b1;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input round-robin arbiter with forced-grant override
// Purpose: picks one of two requesters per cycle. With both requesting the
// pointer owner wins and the pointer then moves to the loser. A forced grant
// overrides the round-robin choice (used by the top for lock ownership and
// the forced lock release).
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_req[1:0]       request vector (bit 0 core, bit 1 debug)
//   i_force_en       take the grant from i_force_idx instead of round-robin
//   i_force_idx      requester index to force
//   o_gnt[1:0]       one-hot (or zero) grant, combinational
module rr_arbiter2
  import k_and_s_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_force_en,
  input  logic       i_force_idx,
  output logic [1:0] o_gnt
);

  logic       r_ptr;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (i_force_en) begin
      // A forced grant still requires the forced side to be requesting.
      w_gnt = onehot2(i_force_idx) & i_req;
    end else begin
      case (i_req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = onehot2(r_ptr);
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign o_gnt = w_gnt;

  // Any contested grant, forced or not, hands priority to the losing side.
  // This is what lets debug resume its locked run right after a forced
  // core release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= IDX_CORE;
    end else if (i_req == 2'b11 && w_gnt != 2'b00) begin
      r_ptr <= ~w_gnt[1];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the single-port RAM between core and debug
// Purpose: grants one of the core or debug requesters per cycle (round-robin,
// with a bounded exclusive lock for debug), drives the RAM from the winner
// and returns synchronous read data to the requester that issued the read.
// Ports:
//   i_clk, i_rst                        clock, asynchronous active-high reset
//   i_core_req/we/addr/wdata            core access request
//   o_core_gnt, o_core_rvalid/rdata     core grant and read return
//   i_dbg_req/we/lock/addr/wdata        debug access request (+ lock)
//   o_dbg_gnt, o_dbg_rvalid/rdata       debug grant and read return
//   o_ram_addr/we/wdata, i_ram_rdata    RAM macro (read data one cycle later)
module ram_port_arbiter
  import k_and_s_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic [DATA_W-1:0] i_core_wdata,
  output logic              o_core_gnt,
  output logic              o_core_rvalid,
  output logic [DATA_W-1:0] o_core_rdata,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic              i_dbg_lock,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_gnt,
  output logic              o_dbg_rvalid,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  localparam logic [7:0] LOCK_LIMIT = 8'(MAX_LOCK);

  arb_state_t r_state;
  arb_owner_t r_owner;
  logic [7:0] r_lock_cnt;

  logic [1:0] w_req;
  logic [1:0] w_gnt;
  logic       w_lock_hold;
  logic       w_release;
  logic       w_force_idx;
  logic       w_core_gnt;
  logic       w_dbg_gnt;

  // Requests are masked during reset so every output reads 0 while rst is
  // high, even if a requester keeps its request asserted.
  assign w_req = {i_dbg_req, i_core_req} & {2{~i_rst}};

  // The lock only persists if the previous grant was a locked debug grant
  // and debug is still asking for it.
  assign w_lock_hold = (r_state == ARB_LOCK) && i_dbg_req && i_dbg_lock;
  assign w_release   = w_lock_hold && i_core_req && (r_lock_cnt == LOCK_LIMIT);
  assign w_force_idx = w_release ? IDX_CORE : IDX_DBG;

  rr_arbiter2 u_rr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (w_req),
    .i_force_en  (w_lock_hold),
    .i_force_idx (w_force_idx),
    .o_gnt       (w_gnt)
  );

  assign w_core_gnt = w_gnt[IDX_CORE];
  assign w_dbg_gnt  = w_gnt[IDX_DBG];
  assign o_core_gnt = w_core_gnt;
  assign o_dbg_gnt  = w_dbg_gnt;

  // RAM port follows the winner in the same cycle; idle port is all zero.
  always_comb begin
    o_ram_addr  = '0;
    o_ram_we    = 1'b0;
    o_ram_wdata = '0;
    if (w_core_gnt) begin
      o_ram_addr  = i_core_addr;
      o_ram_we    = i_core_we;
      o_ram_wdata = i_core_wdata;
    end else if (w_dbg_gnt) begin
      o_ram_addr  = i_dbg_addr;
      o_ram_we    = i_dbg_we;
      o_ram_wdata = i_dbg_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ARB_IDLE;
      r_owner    <= OWN_NONE;
      r_lock_cnt <= 8'd0;
    end else begin
      if (w_core_gnt) begin
        r_state <= ARB_CORE;
      end else if (w_dbg_gnt) begin
        r_state <= i_dbg_lock ? ARB_LOCK : ARB_DBG;
      end else begin
        r_state <= ARB_IDLE;
      end

      // Only locked debug grants that make the core wait count toward the
      // limit; a core grant or a dropped lock/request restarts the count.
      if (w_core_gnt) begin
        r_lock_cnt <= 8'd0;
      end else if (!(i_dbg_req && i_dbg_lock)) begin
        r_lock_cnt <= 8'd0;
      end else if (w_dbg_gnt && i_core_req && (r_lock_cnt < LOCK_LIMIT)) begin
        r_lock_cnt <= r_lock_cnt + 8'd1;
      end

      if (w_core_gnt && !i_core_we) begin
        r_owner <= OWN_CORE;
      end else if (w_dbg_gnt && !i_dbg_we) begin
        r_owner <= OWN_DBG;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  assign o_core_rvalid = (r_owner == OWN_CORE);
  assign o_dbg_rvalid  = (r_owner == OWN_DBG);
  assign o_core_rdata  = o_core_rvalid ? i_ram_rdata : '0;
  assign o_dbg_rdata   = o_dbg_rvalid ? i_ram_rdata : '0;

endmodule
